// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : multicycle ARM-subset controller (FSM, ALU decode,     |
// |                   condition-gated write strobes)      Revision 1.0       |
// +--------------------------------------------------------------------------+
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic       condex,
   input  logic       memready,
   output logic       irwrite,
   output logic       adrsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic [1:0] immsrc,
   output logic [1:0] regsrc,
   output logic [1:0] alucontrol,
   output logic [1:0] flagw,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic       nextpc;
   logic       branch;
   logic       regw;
   logic       memw;
   logic       aluop;

   logic [1:0] alu_ctl;
   logic       alu_known;
   logic       flag_nz;
   logic       flag_cv;
   logic       pc_wr_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      nextpc    = 1'b0;
      branch    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      aluop     = 1'b0;
      adrsrc    = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      resultsrc = 2'b00;

      case (state_q)
         S_FETCH: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            nextpc    = 1'b1;
            if (memready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrcb = 2'b01;
            state_d = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adrsrc = 1'b1;
            if (memready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regw      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            adrsrc = 1'b1;
            memw   = 1'b1;
            if (memready) begin
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            aluop   = 1'b1;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            alusrcb = 2'b01;
            aluop   = 1'b1;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regw    = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alusrcb   = 2'b01;
            resultsrc = 2'b10;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Unrecognised cmd codes fall back to ADD but must never touch the flags.
   always_comb begin
      alu_ctl   = 2'b00;
      alu_known = 1'b1;
      case (funct[4:1])
         4'b0100: alu_ctl = 2'b00;
         4'b0010: alu_ctl = 2'b01;
         4'b0000: alu_ctl = 2'b10;
         4'b1100: alu_ctl = 2'b11;
         default: alu_known = 1'b0;
      endcase
   end

   assign alucontrol = aluop ? alu_ctl : 2'b00;
   assign flag_nz    = aluop & alu_known & funct[0] & condex;
   // ADD and SUB are the only encodings with bit 1 clear
   assign flag_cv    = flag_nz & ~alu_ctl[1];

   // Register-file read-port selects depend only on the instruction class.
   assign immsrc = op;
   assign regsrc = {op == 2'b01, op == 2'b10};

   assign pc_wr_raw = (nextpc & memready) | (condex & (branch | ((rd == 4'b1111) & regw)));

   // Reset gates every write strobe so nothing commits while it is held.
   assign irwrite  = ~reset & nextpc & memready;
   assign pcwrite  = ~reset & pc_wr_raw;
   assign regwrite = ~reset & regw & condex;
   assign memwrite = ~reset & memw & condex & memready;
   assign flagw    = reset ? 2'b00 : {flag_nz, flag_cv};

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; the block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-004 op  in  2  instruction op field from instruction register.
REQ-005 funct  in  6  instruction funct field: [5]=I, [4:1]=cmd, [0]=S or L.
REQ-006 rd  in  4  destination register number.
REQ-007 condex  in  1  condition passed, from the condition unit.
REQ-008 memready  in  1  memory access complete this cycle.
REQ-009 irwrite  out  1  instruction register load enable.
REQ-010 adrsrc  out  1  memory address select: 0=PC, 1=ALU result.
REQ-011 alusrca  out  1  ALU A select: 0=register, 1=PC.
REQ-012 alusrcb  out  2  ALU B select: 00=register, 01=extended imm, 10=constant 4.
REQ-013 resultsrc  out  2  result select: 00=ALUOut, 01=read data, 10=ALU result.
REQ-014 immsrc  out  2  and regsrc  out  2; both are pure combinational decodes of op.
REQ-015 alucontrol  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
REQ-016 flagw  out  2  flag write enables: [1]=NZ, [0]=CV.
REQ-017 pcwrite, regwrite, memwrite  out  1 each  condition-gated write strobes.

Function
REQ-018 State set: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-019 FETCH: adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, nextpc=1.
  - irwrite=memready.
  - FETCH→DECODE when memready=1; otherwise the state SHALL hold.
REQ-020 DECODE: alusrca=1, alusrcb=10, resultsrc=10.
  - op=01 → MEMADR.
  - op=00 with funct[5]=1 → EXECI; funct[5]=0 → EXECR.
  - op=10 → BRANCH.
  - op=11 → FETCH, with no strobe asserted.
REQ-021 MEMADR: alusrca=0, alusrcb=01, aluop=0; → MEMRD if funct[0]=1, else → MEMWR.
REQ-022 MEMRD: adrsrc=1; hold until memready, then → MEMWB.
REQ-023 MEMWB: resultsrc=01, regw=1; → FETCH.
REQ-024 MEMWR: adrsrc=1, memw=1; hold until memready, then → FETCH.
REQ-025 EXECR: alusrca=0, alusrcb=00, aluop=1; → ALUWB.
REQ-026 EXECI: alusrca=0, alusrcb=01, aluop=1; → ALUWB.
REQ-027 ALUWB: resultsrc=00, regw=1; → FETCH.
REQ-028 BRANCH: alusrca=0, alusrcb=01, resultsrc=10, branch=1; → FETCH.
REQ-029 Every output not listed for a state SHALL be 0 in that state.
REQ-030 Strobe equations:
  - regwrite = regw & condex.
  - memwrite = memw & condex & memready.
  - pcwrite = (nextpc & memready) | condex & (branch | (rd==4'b1111 & regw)).
REQ-031 ALU decoding when aluop=1: cmd 0100=ADD, 0010=SUB, 0000=AND, 1100=ORR.
  - Any other cmd SHALL give alucontrol=00 with flagw=00.
  - When aluop=0: alucontrol=00 (ADD) and flagw=00.
REQ-032 Flag writes when aluop=1:
  - flagw[1] = funct[0] & condex.
  - flagw[0] = funct[0] & condex & (ADD|SUB).
REQ-033 A failed condition (condex=0) SHALL still traverse the same states, with all gated strobes at 0.
REQ-034 Every instruction SHALL take the following minimum latencies with memready=1 throughout:
  - LDR 5 cycles.
  - STR 4 cycles.
  - data-processing 4 cycles.
  - B 3 cycles.
  - each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.

Reset
REQ-035 Reset assertion SHALL force the state to FETCH immediately, regardless of the clock.
REQ-036 While reset=1, irwrite, pcwrite, regwrite, memwrite and flagw SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard the in-flight instruction with no further write strobe.
REQ-038 On the first rising edge after deassertion, FETCH behaviour SHALL resume.

Verification
REQ-039 ADD imm, S=1, memready=1, condex=1 (op=00, funct=101001) →
  - states FETCH, DECODE, EXECI, ALUWB.
  - flagw=11 in EXECI.
  - regwrite=1 in ALUWB.
REQ-040 LDR, rd=15, memready low for 2 cycles in MEMRD →
  - MEMRD held for 3 cycles.
  - MEMWB asserts regwrite=1 and pcwrite=1.
  - total 7 cycles.
REQ-041 STR with condex=0 →
  - states FETCH, DECODE, MEMADR, MEMWR.
  - memwrite never 1.
  - return to FETCH.
REQ-042 B, condex=1 → pcwrite=1 in FETCH and BRANCH; op=11 → DECODE returns to FETCH with no strobes.
REQ-043 Reset pulse mid-EXECR →
  - FETCH asynchronously.
  - regwrite stays 0.
  - next fetch proceeds normally.
